gate_sweep_ctrl: RTL
====================

# gate_sweep_ctrl

Sequencer that exhaustively exercises the team's 3-input gate network (AND/NOT/OR cell with inputs a, b, c and outputs e = ~c, f = (a & b) | ~c). On a start pulse it walks all 8 input vectors and waits a programmable settle time per vector. It checks each sampled output pair against the built-in golden function, then reports an error count and a pass flag. It sits beside the gate network as its on-chip self-test controller: the network's inputs are driven only by this block, and its outputs are observed only by this block.

## Interface
- SETTLE, 1, cycles waited after applying each vector before sampling; legal range 1–15.

- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  sweep request; sampled only in IDLE.
- a  out  1  drives network input a = vec[2].
- b  out  1  drives network input b = vec[1].
- c  out  1  drives network input c = vec[0].
- e  in  1  network output e, sampled in CHECK.
- f  in  1  network output f, sampled in CHECK.
- busy  out  1  high in SETTLE and CHECK.
- done  out  1  one-cycle pulse in DONE.
- pass  out  1  registered result: 1 if err_cnt == 0 at sweep end; held until next accepted start.
- err_cnt  out  4  number of mismatching vectors in current/last sweep, 0–8.

## Operation
- Reset values: vec = 0 (a = b = c = 0); busy, done, pass = 0; err_cnt = 0; state IDLE; settle counter = 0.
- States: IDLE, SETTLE, CHECK, DONE; encoding is free.
- IDLE:
  - start = 1 → vec <= 0, err_cnt <= 0, pass <= 0, settle counter <= 0, go to SETTLE.
  - start = 0 → stay in IDLE.
- SETTLE: counter increments each cycle. After exactly SETTLE cycles in this state, go to CHECK.
- CHECK: one cycle.
  - Expected values: exp_e = ~vec[0], exp_f = (vec[2] & vec[1]) | ~vec[0].
  - If {e, f} != {exp_e, exp_f}, err_cnt <= err_cnt + 1.
  - If vec == 7, go to DONE and load pass <= (final err_cnt == 0), including this cycle's compare.
  - Otherwise vec <= vec + 1, counter <= 0, go to SETTLE.
- DONE: done = 1 for one cycle, then go to IDLE. vec stays 7; err_cnt and pass hold.
- start is ignored in SETTLE, CHECK and DONE. It is not queued.
- Reset mid-sweep: the next cycle is IDLE with all outputs at their reset values. The partial result is discarded.
- vec never wraps within a sweep. err_cnt cannot exceed 8, so it needs no saturation logic.

## Timing
- a, b, c are registered. A new vector appears the cycle after the CHECK (or the IDLE start) that selected it.
- Per-vector cost: SETTLE + 1 cycles.
- Start sampled high in cycle 0 → done high in cycle 1 + 8·(SETTLE + 1). With SETTLE = 1 that is cycle 17.
- busy rises in cycle 1 and falls in the DONE cycle.
- A start in cycle 18 (IDLE again) begins a new sweep. The earliest back-to-back start is therefore the cycle after done.
- e and f are treated as combinational functions of a, b and c. SETTLE covers any network delay.

## Configuration
- GATE_SWEEP_FAIL_CAP_EN defined: adds three outputs.
  - fail_valid (1)
  - fail_vec (3)
  - fail_ef (2, observed {e, f})
  - The first mismatching CHECK of a sweep loads fail_vec and fail_ef and sets fail_valid. Later mismatches do not overwrite them.
  - All three clear to 0 on reset and on an accepted start.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

## Test plan
- Golden network, SETTLE = 1, start pulse in cycle 0 → done in cycle 17, err_cnt = 0, pass = 1, a/b/c sequence 000…111.
- f stuck at 0 → mismatches at vec 0, 2, 4, 6, 7. Result: err_cnt = 5, pass = 0. With the macro: fail_vec = 0, fail_ef = 2'b10.
- e wired as c (inverter missing) → all 8 vectors mismatch, err_cnt = 8, pass = 0. With the macro: fail_vec = 0, fail_ef = 2'b01.
- start held high for the whole sweep → exactly one sweep runs, and done occurs in cycle 17. start still high in cycle 18 begins a second sweep, and err_cnt clears.
- reset asserted in cycle 9 of a sweep → cycle 10: IDLE, busy = 0, err_cnt = 0, a = b = c = 0; no done pulse.
- SETTLE = 3, golden network → done in cycle 33. e and f are sampled only in cycles 4, 8, …, 32.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the 3-input AND/NOT/OR gate network: walks all 8 input vectors and compares e/f against the golden function.
// Optional first-failure capture ports are enabled by defining GATE_SWEEP_FAIL_CAP_EN.
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       e,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt
`ifdef GATE_SWEEP_FAIL_CAP_EN
  ,
  output logic       fail_valid,
  output logic [2:0] fail_vec,
  output logic [1:0] fail_ef
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  // Golden network: e = ~c, f = (a & b) | ~c
  assign mismatch = ({e, f} != {~vec_q[0], (vec_q[2] & vec_q[1]) | ~vec_q[0]});

`ifdef GATE_SWEEP_FAIL_CAP_EN
  logic       fv_q, fv_d;
  logic [2:0] fvec_q, fvec_d;
  logic [1:0] fef_q, fef_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
`ifdef GATE_SWEEP_FAIL_CAP_EN
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      fef_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
`ifdef GATE_SWEEP_FAIL_CAP_EN
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      fef_q   <= fef_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    busy    = 1'b0;
    done    = 1'b0;
`ifdef GATE_SWEEP_FAIL_CAP_EN
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    fef_d   = fef_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = S_SETTLE;
`ifdef GATE_SWEEP_FAIL_CAP_EN
          fv_d    = 1'b0;
          fvec_d  = '0;
          fef_d   = '0;
`endif
        end
      end
      S_SETTLE: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q + 4'd1 == SETTLE_C) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (mismatch) begin
          err_d = err_q + 4'd1;
`ifdef GATE_SWEEP_FAIL_CAP_EN
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
            fef_d  = {e, f};
          end
`endif
        end
        // The last vector's compare must be folded into the pass verdict.
        if (vec_q == 3'd7) begin
          pass_d  = (err_d == 4'd0);
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign a       = vec_q[2];
  assign b       = vec_q[1];
  assign c       = vec_q[0];
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef GATE_SWEEP_FAIL_CAP_EN
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
  assign fail_ef    = fef_q;
`endif

endmodule
